// File: rtl/data_mem_pipe.sv
// Data memory with request/ready handshake, 1-cycle registered read, post-reset clear sweep
// and out-of-range flagging. Optional access counters: define DATA_MEM_PIPE_STATS_EN.
module data_mem_pipe #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_in,
  input  logic              write_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  output logic              busy_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              err_out,
  output logic [15:0]       rd_count_out,
  output logic [15:0]       wr_count_out
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  // One extra bit so DEPTH == 2**ADDR_W still compares and terminates correctly.
  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   clear_ptr_q, clear_ptr_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              accept;
  logic              in_range;

  assign accept   = (state_q == S_READY) && req_in;
  assign in_range = ({1'b0, addr_in} < DEPTH_EXT);

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    data_d      = data_q;
    mem_we      = 1'b0;
    mem_waddr   = addr_in;
    mem_wdata   = data_in;
    case (state_q)
      S_CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clear_ptr_q[ADDR_W-1:0];
        mem_wdata   = INIT_VAL;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == LAST_IDX) state_d = S_READY;
      end
      default: begin
        if (accept) begin
          err_d = !in_range;
          if (write_in) begin
            mem_we = in_range;
          end else begin
            valid_d = 1'b1;
            data_d  = in_range ? mem[addr_in] : '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_CLEAR;
      clear_ptr_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      data_q      <= data_d;
    end
  end

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign ready_out = (state_q == S_READY);
  assign busy_out  = (state_q == S_CLEAR);
  assign valid_out = valid_q;
  assign err_out   = err_q;
  assign data_out  = data_q;

`ifdef DATA_MEM_PIPE_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (accept && !write_in && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
    if (accept &&  write_in && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count_out = rd_cnt_q;
  assign wr_count_out = wr_cnt_q;
`else
  assign rd_count_out = 16'h0000;
  assign wr_count_out = 16'h0000;
`endif

endmodule

// File: doc/data_mem_pipe.md
Name: data_mem_pipe

Overview:
- Parametrised successor to the 8-bit/256-entry data memory; sits between the processor datapath and the memory array.
- Adds a request/ready handshake and a registered (1-cycle) read.
- After reset, a hardware clear sweep writes INIT_VAL into every entry.
- Out-of-range accesses are flagged instead of aliased.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of implemented entries; legal range 1 to 2**ADDR_W.
- INIT_VAL, 0, value written to every entry by the clear sweep (DATA_W bits).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- req_in  input  1  request valid this cycle.
- write_in  input  1  1 = write, 0 = read; sampled only when req_in=1.
- addr_in  input  ADDR_W  access address.
- data_in  input  DATA_W  write data.
- ready_out  output  1  block accepts a request this cycle.
- busy_out  output  1  clear sweep in progress.
- valid_out  output  1  one-cycle pulse: data_out holds a new read result.
- data_out  output  DATA_W  read data; holds the last read value between reads.
- err_out  output  1  one-cycle pulse: the previously accepted access had addr_in >= DEPTH.
- rd_count_out  output  16  read counter (see Optional Feature).
- wr_count_out  output  16  write counter (see Optional Feature).

Behaviour:
- Reset values while RST=1 (asynchronous):
  - state=CLEAR, clear_ptr=0.
  - ready_out=0, busy_out=1, valid_out=0, err_out=0, data_out=0.
  - Counters = 0.
  - Array contents are not reset directly.
- State CLEAR:
  - Each rising edge writes INIT_VAL to mem[clear_ptr], then clear_ptr increments.
  - On the edge that writes mem[DEPTH-1]: state -> READY, ready_out=1, busy_out=0.
  - The sweep takes exactly DEPTH edges after RST deasserts.
  - req_in is ignored in CLEAR: no write, no valid_out, no err_out, no counter change.
- State READY:
  - ready_out=1 continuously. A request is accepted on any edge where req_in=1.
  - Accepted write, addr_in < DEPTH: mem[addr_in] <= data_in at that edge. No valid_out.
  - Accepted read, addr_in < DEPTH: data_out <= mem[addr_in] and valid_out=1 for the following cycle. Read latency is 1 edge.
  - Read-after-write to the same address on consecutive cycles returns the newly written value; no stale read.
  - Accepted access, addr_in >= DEPTH:
    - The array is not modified.
    - err_out=1 for the following cycle.
    - A read also sets data_out <= 0 and pulses valid_out.
  - req_in=0: no state change, valid_out=0, data_out holds.
  - Back-to-back requests every cycle are legal; throughput is 1 access per cycle.
- Reset mid-operation (RST asserted in READY or part-way through CLEAR):
  - Immediately returns to the reset values.
  - The sweep restarts from address 0 once RST deasserts.
- Width rules:
  - Only addr_in[ADDR_W-1:0] is used.
  - clear_ptr is ADDR_W+1 bits so that DEPTH=2**ADDR_W terminates correctly.

Optional Feature:
- Macro DATA_MEM_PIPE_STATS_EN.
- Defined:
  - rd_count_out increments on every accepted read; wr_count_out increments on every accepted write.
  - Out-of-range accesses are counted too.
  - Both are 16-bit counters that saturate at 16'hFFFF (no wrap).
  - Both are cleared only by RST.
- Not defined: rd_count_out and wr_count_out are tied to 0 and no counter flops are built. The ports exist in both builds.

Test Plan:
- Reset/clear, DEPTH=256, INIT_VAL=8'hA5: deassert RST -> ready_out=0 and busy_out=1 for exactly 256 edges, then ready_out=1 and busy_out=0; reads of addr 0, 17 and 255 return 8'hA5 with valid_out pulsing 1 cycle after each request.
- Write then read: write 33 to addr 43, read addr 43 on the next cycle -> valid_out=1 and data_out=33 one cycle after the read; data_out still 33 two idle cycles later.
- Requests during CLEAR: req_in=1, write_in=1, addr 0, data 99 during the sweep -> ignored; after ready_out rises, read addr 0 returns INIT_VAL; counters = 0.
- Out of range with DEPTH=200:
  - write 7 to addr 210 -> err_out pulses 1 cycle, no array change.
  - read addr 210 -> data_out=0, valid_out=1, err_out=1.
  - read addr 199 -> INIT_VAL, err_out=0.
- Reset mid-sweep: assert RST at sweep edge 100 for 2 cycles -> all outputs return to reset values; after deassert, ready_out rises exactly DEPTH edges later.
- With DATA_MEM_PIPE_STATS_EN: 3 writes and 5 reads back-to-back -> wr_count_out=3, rd_count_out=5. Preload the counter to 16'hFFFE via 2 extra forced accesses -> it holds at 16'hFFFF. Without the macro, both ports read 0 throughout.
